// File: rtl/sps_rx_ctrl.sv
// sps_rx_ctrl -- oversampling serial receive controller.
//
// Synchronises the raw serial line, detects the start edge, steers an
// external 10-bit shift register with one-cycle shift strobes at the middle
// of each bit cell, then latches the payload and reports status.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   serialIn   raw asynchronous serial line (idle high)
//   shiftEn    one-cycle strobe: shift register must shift in serialOut
//   serialOut  synchronised line bit presented to the shift register
//   data       shift register contents (data[0]=start, [8:1]=payload, [9]=stop)
//   rxData     payload of the last completed frame
//   charReady  rxData holds an unacknowledged character
//   charAck    consumer acknowledge (clears charReady, frameErr, overrun)
//   frameErr   sticky: last completed frame had a bad start or stop bit
//   overrun    sticky: a frame completed while charReady was still high
//   busy       controller is not idle
module sps_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serialIn,
  output logic                  shiftEn,
  output logic                  serialOut,
  input  logic [FRAME_BITS-1:0] data,
  output logic [7:0]            rxData,
  output logic                  charReady,
  input  logic                  charAck,
  output logic                  frameErr,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  // Start bit is re-checked half a bit period after the edge; data bits are
  // then sampled once per full period, landing near each cell centre.
  localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_LATCH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   samp_q, samp_d;
  logic [3:0]      bit_q, bit_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [7:0]      rxData_q, rxData_d;
  logic            charReady_q, charReady_d;
  logic            frameErr_q, frameErr_d;
  logic            overrun_q, overrun_d;
  logic            shift_pulse;
  logic            ack_clr;
  logic            frame_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      samp_q      <= '0;
      bit_q       <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      rxData_q    <= 8'h00;
      charReady_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      sync1_q     <= serialIn;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      rxData_q    <= rxData_d;
      charReady_q <= charReady_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ack_clr   = charAck & charReady_q;
  assign frame_bad = data[0] | ~data[FRAME_BITS-1];

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_pulse = 1'b0;
    rxData_d    = rxData_q;
    charReady_d = charReady_q;
    frameErr_d  = frameErr_q;
    overrun_d   = overrun_q;

    // An acknowledge of a pending character clears all status together.
    if (ack_clr) begin
      charReady_d = 1'b0;
      frameErr_d  = 1'b0;
      overrun_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        samp_d = '0;
        bit_d  = '0;
        // prev_q holds the previous synchronised bit, so this is a 1->0 edge.
        if (prev_q && !sync2_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (samp_q == HALF_CNT) begin
          samp_d = '0;
          if (!sync2_q) begin
            shift_pulse = 1'b1;
            bit_d       = 4'd1;
            state_d     = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      S_DATA: begin
        if (samp_q == LAST_CNT) begin
          samp_d      = '0;
          shift_pulse = 1'b1;
          bit_d       = bit_q + 4'd1;
          if (bit_q == LAST_BIT) begin
            state_d = S_LATCH;
          end
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      S_LATCH: begin
        // Completion wins over a same-cycle acknowledge: the character stays
        // ready, and an ack in this cycle prevents the overrun flag.
        rxData_d    = data[8:1];
        charReady_d = 1'b1;
        frameErr_d  = frameErr_d | frame_bad;
        overrun_d   = overrun_d | (charReady_q & ~charAck);
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign shiftEn   = shift_pulse;
  assign serialOut = sync2_q;
  assign rxData    = rxData_q;
  assign charReady = charReady_q;
  assign frameErr  = frameErr_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sps_rx_ctrl.sv
// Directed bench for sps_rx_ctrl: one instance at OVERSAMPLE=4 and one at
// OVERSAMPLE=16, each feeding a behavioural 10-bit shift register.
module tb_sps_rx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       serialIn4 = 1'b1;
  logic       charAck4  = 1'b0;
  logic       shiftEn4, serialOut4, charReady4, frameErr4, overrun4, busy4;
  logic [7:0] rxData4;
  logic [9:0] sr4 = '0;

  logic       serialIn16 = 1'b1;
  logic       charAck16  = 1'b0;
  logic       shiftEn16, serialOut16, charReady16, frameErr16, overrun16, busy16;
  logic [7:0] rxData16;
  logic [9:0] sr16 = '0;

  sps_rx_ctrl #(.OVERSAMPLE(4), .FRAME_BITS(10)) u4 (
    .clk(clk), .rst(rst), .serialIn(serialIn4), .shiftEn(shiftEn4),
    .serialOut(serialOut4), .data(sr4), .rxData(rxData4),
    .charReady(charReady4), .charAck(charAck4), .frameErr(frameErr4),
    .overrun(overrun4), .busy(busy4)
  );

  sps_rx_ctrl #(.OVERSAMPLE(16), .FRAME_BITS(10)) u16 (
    .clk(clk), .rst(rst), .serialIn(serialIn16), .shiftEn(shiftEn16),
    .serialOut(serialOut16), .data(sr16), .rxData(rxData16),
    .charReady(charReady16), .charAck(charAck16), .frameErr(frameErr16),
    .overrun(overrun16), .busy(busy16)
  );

  // External shift registers: LSB-first, so the start bit ends in bit 0.
  always @(posedge clk) if (shiftEn4)  sr4  <= {serialOut4,  sr4[9:1]};
  always @(posedge clk) if (shiftEn16) sr16 <= {serialOut16, sr16[9:1]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0;
  int   fails = 0;
  int   se4[$];
  int   se16[$];
  int   cr4_rise = -1;
  int   busy16_rise = -1;
  logic cr4_prev = 1'b0;
  logic busy16_prev = 1'b0;
  logic busy4_seen = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge and log output events of that cycle.
  task automatic tick();
    @(negedge clk);
    if (shiftEn4)  se4.push_back(cyc);
    if (shiftEn16) se16.push_back(cyc);
    if (charReady4 && !cr4_prev) cr4_rise = cyc;
    cr4_prev = charReady4;
    if (busy16 && !busy16_prev) busy16_rise = cyc;
    busy16_prev = busy16;
    if (busy4) busy4_seen = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic [7:0] p, input logic stop);
    return {stop, p, 1'b0};
  endfunction

  // Drive the first n bits of frame f, one bit per oversample period.
  task automatic drive_bits(input logic [9:0] f, input int n, input bit use16);
    int os = use16 ? 16 : 4;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < os; k++) begin
        tick();
        if (use16) serialIn16 = f[i];
        else       serialIn4  = f[i];
      end
    end
  endtask

  // Wait (bounded) until n shift pulses are logged; optionally idle the line.
  task automatic wait_pulses(input int n, input bit use16, input bit set_idle);
    int b = 0;
    while (((use16 ? se16.size() : se4.size()) < n) && b < 400) begin
      tick();
      if (set_idle) begin
        if (use16) serialIn16 = 1'b1;
        else       serialIn4  = 1'b1;
      end
      b++;
    end
    if (b >= 400) chk("pulse_wait_timeout", use16 ? se16.size() : se4.size(), n);
  endtask

  task automatic ack4();
    tick(); charAck4 = 1'b1;
    tick(); charAck4 = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_rxData",    rxData4,    8'h00);
    chk("rst_charReady", charReady4, 1'b0);
    chk("rst_frameErr",  frameErr4,  1'b0);
    chk("rst_overrun",   overrun4,   1'b0);
    chk("rst_busy",      busy4,      1'b0);
    chk("rst_serialOut", serialOut4, 1'b1);
    chk("rst_shiftEn",   shiftEn4,   1'b0);
    rst = 1'b0;
    repeat (4) tick();

    // Frame 0x55
    se4.delete();
    cr4_rise = -1;
    drive_bits(mk(8'h55, 1'b1), 10, 1'b0);
    wait_pulses(10, 1'b0, 1'b1);
    repeat (3) tick();
    chk("f55_pulses", se4.size(), 10);
    for (int i = 1; i < se4.size(); i++) chk("f55_spacing", se4[i] - se4[i-1], 4);
    chk("f55_ready_lat", cr4_rise - se4[9], 2);
    chk("f55_rxData",    rxData4,    8'h55);
    chk("f55_charReady", charReady4, 1'b1);
    chk("f55_frameErr",  frameErr4,  1'b0);
    chk("f55_busy",      busy4,      1'b0);
    ack4();
    chk("f55_ack_clear", charReady4, 1'b0);

    // Two-cycle low glitch on the idle line
    se4.delete();
    busy4_seen = 1'b0;
    tick(); serialIn4 = 1'b0;
    tick();
    tick(); serialIn4 = 1'b1;
    repeat (8) tick();
    chk("glitch_started",   busy4_seen, 1'b1);
    chk("glitch_noshift",   se4.size(), 0);
    chk("glitch_busy",      busy4,      1'b0);
    chk("glitch_charReady", charReady4, 1'b0);

    // Frame 0xA3 with a bad stop bit
    se4.delete();
    drive_bits(mk(8'hA3, 1'b0), 10, 1'b0);
    wait_pulses(10, 1'b0, 1'b1);
    repeat (3) tick();
    chk("fA3_rxData",    rxData4,    8'hA3);
    chk("fA3_charReady", charReady4, 1'b1);
    chk("fA3_frameErr",  frameErr4,  1'b1);
    ack4();
    chk("fA3_ack_ready", charReady4, 1'b0);
    chk("fA3_ack_ferr",  frameErr4,  1'b0);
    chk("fA3_ack_ovr",   overrun4,   1'b0);

    // Back-to-back 0x11, 0x22 without acknowledge
    se4.delete();
    drive_bits(mk(8'h11, 1'b1), 10, 1'b0);
    drive_bits(mk(8'h22, 1'b1), 10, 1'b0);
    wait_pulses(20, 1'b0, 1'b1);
    repeat (3) tick();
    chk("b2b_rxData",    rxData4,    8'h22);
    chk("b2b_overrun",   overrun4,   1'b1);
    chk("b2b_charReady", charReady4, 1'b1);
    chk("b2b_frameErr",  frameErr4,  1'b0);
    ack4();
    chk("b2b_ack_ovr",   overrun4,   1'b0);
    chk("b2b_ack_ready", charReady4, 1'b0);

    // Back-to-back again, acknowledge in the LATCH cycle of frame 2
    se4.delete();
    drive_bits(mk(8'h11, 1'b1), 10, 1'b0);
    drive_bits(mk(8'h22, 1'b1), 10, 1'b0);
    wait_pulses(20, 1'b0, 1'b1);
    tick(); charAck4 = 1'b1;
    tick(); charAck4 = 1'b0;
    repeat (2) tick();
    chk("latack_overrun",   overrun4,   1'b0);
    chk("latack_charReady", charReady4, 1'b1);
    chk("latack_rxData",    rxData4,    8'h22);

    // Reset after the 5th shift pulse of a frame
    se4.delete();
    drive_bits(mk(8'h96, 1'b1), 5, 1'b0);
    wait_pulses(5, 1'b0, 1'b0);
    rst = 1'b1;
    serialIn4 = 1'b1;
    #1;
    chk("midrst_rxData",    rxData4,    8'h00);
    chk("midrst_charReady", charReady4, 1'b0);
    chk("midrst_overrun",   overrun4,   1'b0);
    chk("midrst_frameErr",  frameErr4,  1'b0);
    chk("midrst_busy",      busy4,      1'b0);
    chk("midrst_shiftEn",   shiftEn4,   1'b0);
    chk("midrst_serialOut", serialOut4, 1'b1);
    tick();
    rst = 1'b0;
    repeat (50) tick();
    chk("midrst_nolatch", charReady4, 1'b0);
    chk("midrst_idle",    busy4,      1'b0);
    se4.delete();
    drive_bits(mk(8'h3C, 1'b1), 10, 1'b0);
    wait_pulses(10, 1'b0, 1'b1);
    repeat (3) tick();
    chk("f3C_pulses",    se4.size(), 10);
    chk("f3C_rxData",    rxData4,    8'h3C);
    chk("f3C_charReady", charReady4, 1'b1);
    chk("f3C_frameErr",  frameErr4,  1'b0);

    // OVERSAMPLE=16 instance, frame 0xFF
    se16.delete();
    busy16_rise = -1;
    drive_bits(mk(8'hFF, 1'b1), 10, 1'b1);
    wait_pulses(10, 1'b1, 1'b1);
    repeat (3) tick();
    chk("os16_pulses", se16.size(), 10);
    chk("os16_first",  se16[0] - busy16_rise, 7);
    for (int i = 1; i < se16.size(); i++) chk("os16_spacing", se16[i] - se16[i-1], 16);
    chk("os16_rxData",    rxData16,    8'hFF);
    chk("os16_charReady", charReady16, 1'b1);
    chk("os16_frameErr",  frameErr16,  1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
